rvlab_jtag_dtm: RTL and testbench

RISC-V Debug Transport Module (spec 0.13) on the FPGA side of the board JTAG pins. It is the responder to the testbench JTAG master. It oversamples TCK/TMS/TDI in the system clock domain and runs the 16-state TAP controller. It exposes the IDCODE, DTMCS, DMI and BYPASS data registers, and converts DMI scans into a valid/ready request/response handshake toward the debug module.

---
 rtl/rvlab_jtag_pkg.sv | 58 +++++
 rtl/rvlab_jtag_dtm_if.sv | 22 ++
 rtl/rvlab_jtag_edge_sync.sv | 52 +++++
 rtl/rvlab_jtag_dtm.sv | 208 ++++++++++++++++++++
 tb/tb_rvlab_jtag_dtm.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rvlab_jtag_pkg.sv
// Shared types and constants for the RISC-V JTAG debug transport module.
package rvlab_jtag_pkg;

    localparam int unsigned IrWidth         = 5;
    localparam int unsigned DmiAbitsDefault = 7;

    localparam logic [IrWidth-1:0] IrIdcode  = 5'h01;
    localparam logic [IrWidth-1:0] IrDtmcs   = 5'h10;
    localparam logic [IrWidth-1:0] IrDmi     = 5'h11;
    localparam logic [IrWidth-1:0] IrBypass  = 5'h1f;
    localparam logic [IrWidth-1:0] IrCapture = 5'b00001;

    localparam logic [1:0] DmiOpRead     = 2'd1;
    localparam logic [1:0] DmiOpWrite    = 2'd2;
    localparam logic [1:0] DmiStatOk     = 2'd0;
    localparam logic [1:0] DmiStatFailed = 2'd2;
    localparam logic [1:0] DmiStatBusy   = 2'd3;

    localparam logic [3:0]  DtmcsVersion      = 4'd1;
    localparam logic [2:0]  DtmcsIdle         = 3'd1;
    localparam int unsigned DtmcsDmiresetBit  = 16;
    localparam int unsigned DtmcsHardresetBit = 17;

    typedef enum logic [3:0] {
        TapTestLogicReset, TapRunTestIdle,
        TapSelectDr, TapCaptureDr, TapShiftDr, TapExit1Dr, TapPauseDr, TapExit2Dr, TapUpdateDr,
        TapSelectIr, TapCaptureIr, TapShiftIr, TapExit1Ir, TapPauseIr, TapExit2Ir, TapUpdateIr
    } tap_state_e;

    typedef enum logic [1:0] {DrIdcode, DrDtmcs, DrDmi, DrBypass} dr_sel_e;
    typedef enum logic [1:0] {DmiIdle, DmiReq, DmiRsp} dmi_state_e;

    typedef struct packed {
        logic [DmiAbitsDefault-1:0] addr;
        logic [31:0]                data;
        logic [1:0]                 op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_rsp_t;

    function automatic dr_sel_e decode_ir(input logic [IrWidth-1:0] ir);
        case (ir)
            IrIdcode: return DrIdcode;
            IrDtmcs:  return DrDtmcs;
            IrDmi:    return DrDmi;
            IrBypass: return DrBypass;
            default:  return DrBypass;
        endcase
    endfunction

    function automatic logic is_ir_state(input tap_state_e s);
        return s inside {TapCaptureIr, TapShiftIr, TapExit1Ir, TapPauseIr, TapExit2Ir, TapUpdateIr};
    endfunction

endpackage

// File: rtl/rvlab_jtag_dtm_if.sv
// DMI request/response handshake between the DTM (master) and the debug module (slave).
interface rvlab_jtag_dtm_if #(
    parameter int unsigned AbitsWidth = 7
);
    logic                  dmi_req_valid_o;
    logic                  dmi_req_ready_i;
    logic [AbitsWidth+33:0] dmi_req_o;
    logic                  dmi_rsp_valid_i;
    logic                  dmi_rsp_ready_o;
    logic [31:0]           dmi_rsp_data_i;
    logic [1:0]            dmi_rsp_resp_i;

    modport master (
        output dmi_req_valid_o, dmi_req_o, dmi_rsp_ready_o,
        input  dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i
    );

    modport slave (
        input  dmi_req_valid_o, dmi_req_o, dmi_rsp_ready_o,
        output dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i
    );
endinterface

// File: rtl/rvlab_jtag_edge_sync.sv
// Synchronizes the JTAG pins into clk_i and derives one-cycle TCK rise/fall pulses.
// RVLAB_JTAG_TRST_EN: also synchronize TRST; otherwise TRST is tied inactive.
module rvlab_jtag_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_tck,
    input  logic i_tms,
    input  logic i_tdi,
    input  logic i_trst_n,
    output logic o_tck_rise_c,
    output logic o_tck_fall_c,
    output logic o_tms,
    output logic o_tdi,
    output logic o_trst_n
);
    logic [1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
    logic       r_tck_hist;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_hist <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[0], i_tck};
            r_tms_sync <= {r_tms_sync[0], i_tms};
            r_tdi_sync <= {r_tdi_sync[0], i_tdi};
            r_tck_hist <= r_tck_sync[1];
        end
    end

    assign o_tck_rise_c = r_tck_sync[1] & ~r_tck_hist;
    assign o_tck_fall_c = ~r_tck_sync[1] & r_tck_hist;
    assign o_tms        = r_tms_sync[1];
    assign o_tdi        = r_tdi_sync[1];

`ifdef RVLAB_JTAG_TRST_EN
    logic [1:0] r_trst_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_trst_sync <= '0;
        else         r_trst_sync <= {r_trst_sync[0], i_trst_n};
    end

    assign o_trst_n = r_trst_sync[1];
`else
    logic w_unused_trst;
    assign w_unused_trst = i_trst_n;
    assign o_trst_n      = 1'b1;
`endif
endmodule

// File: rtl/rvlab_jtag_dtm.sv
// RISC-V debug transport module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS and a DMI handshake.
// RVLAB_JTAG_TRST_EN (in rvlab_jtag_edge_sync) enables the jtag_trst_ni TAP reset.
module rvlab_jtag_dtm
    import rvlab_jtag_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h0000_0001,
    parameter int unsigned AbitsWidth  = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             jtag_tck_i,
    input  logic             jtag_tms_i,
    input  logic             jtag_tdi_i,
    input  logic             jtag_trst_ni,
    output logic             jtag_tdo_o,
    output logic             jtag_tdo_oe_o,
    rvlab_jtag_dtm_if.master dmi
);
    localparam int unsigned DmiWidth = AbitsWidth + 34;
    localparam int unsigned DrWidth  = DmiWidth;
    localparam int unsigned DrIdxW   = $clog2(DrWidth);

    logic w_tck_rise, w_tck_fall, w_tms, w_tdi, w_trst_n;

    rvlab_jtag_edge_sync u_edge_sync (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_tck        (jtag_tck_i),
        .i_tms        (jtag_tms_i),
        .i_tdi        (jtag_tdi_i),
        .i_trst_n     (jtag_trst_ni),
        .o_tck_rise_c (w_tck_rise),
        .o_tck_fall_c (w_tck_fall),
        .o_tms        (w_tms),
        .o_tdi        (w_tdi),
        .o_trst_n     (w_trst_n)
    );

    tap_state_e r_tap_state, w_tap_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_tap_state <= TapTestLogicReset;
        else if (!w_trst_n) r_tap_state <= TapTestLogicReset;
        else                r_tap_state <= w_tap_next;
    end

    // IEEE 1149.1 TAP transitions, advanced only on a TCK rise pulse
    always_comb begin
        w_tap_next = r_tap_state;
        if (w_tck_rise) begin
            case (r_tap_state)
                TapTestLogicReset: w_tap_next = w_tms ? TapTestLogicReset : TapRunTestIdle;
                TapRunTestIdle:    w_tap_next = w_tms ? TapSelectDr : TapRunTestIdle;
                TapSelectDr:       w_tap_next = w_tms ? TapSelectIr : TapCaptureDr;
                TapCaptureDr:      w_tap_next = w_tms ? TapExit1Dr  : TapShiftDr;
                TapShiftDr:        w_tap_next = w_tms ? TapExit1Dr  : TapShiftDr;
                TapExit1Dr:        w_tap_next = w_tms ? TapUpdateDr : TapPauseDr;
                TapPauseDr:        w_tap_next = w_tms ? TapExit2Dr  : TapPauseDr;
                TapExit2Dr:        w_tap_next = w_tms ? TapUpdateDr : TapShiftDr;
                TapUpdateDr:       w_tap_next = w_tms ? TapSelectDr : TapRunTestIdle;
                TapSelectIr:       w_tap_next = w_tms ? TapTestLogicReset : TapCaptureIr;
                TapCaptureIr:      w_tap_next = w_tms ? TapExit1Ir  : TapShiftIr;
                TapShiftIr:        w_tap_next = w_tms ? TapExit1Ir  : TapShiftIr;
                TapExit1Ir:        w_tap_next = w_tms ? TapUpdateIr : TapPauseIr;
                TapPauseIr:        w_tap_next = w_tms ? TapExit2Ir  : TapPauseIr;
                TapExit2Ir:        w_tap_next = w_tms ? TapUpdateIr : TapShiftIr;
                TapUpdateIr:       w_tap_next = w_tms ? TapSelectDr : TapRunTestIdle;
                default:           w_tap_next = TapTestLogicReset;
            endcase
        end
    end

    logic w_capture_dr, w_shift_dr, w_update_dr, w_capture_ir, w_shift_ir, w_update_ir;
    assign w_capture_dr = w_tck_rise && (r_tap_state == TapCaptureDr);
    assign w_shift_dr   = w_tck_rise && (r_tap_state == TapShiftDr);
    assign w_update_dr  = w_tck_rise && (r_tap_state == TapUpdateDr);
    assign w_capture_ir = w_tck_rise && (r_tap_state == TapCaptureIr);
    assign w_shift_ir   = w_tck_rise && (r_tap_state == TapShiftIr);
    assign w_update_ir  = w_tck_rise && (r_tap_state == TapUpdateIr);

    logic [IrWidth-1:0] r_ir_shift, r_ir;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ir_shift <= '0;
            r_ir       <= IrIdcode;
        end else begin
            if (w_capture_ir)    r_ir_shift <= IrCapture;
            else if (w_shift_ir) r_ir_shift <= {w_tdi, r_ir_shift[IrWidth-1:1]};
            if (!w_trst_n || r_tap_state == TapTestLogicReset) r_ir <= IrIdcode;
            else if (w_update_ir)                              r_ir <= r_ir_shift;
        end
    end

    dmi_state_e            r_dmi_state, w_dmi_next;
    logic                  r_req_valid, r_rsp_ready, r_discard;
    logic [DmiWidth-1:0]   r_req;
    logic [AbitsWidth-1:0] r_last_addr;
    dmi_rsp_t              r_last_rsp;
    logic [1:0]            r_dmistat;
    logic [DrWidth-1:0]    r_dr, w_dr_shifted, w_dr_capture;
    logic [DrIdxW-1:0]     w_dr_msb;
    dr_sel_e               w_dr_sel;

    // A response accepted in the same cycle as Capture-DR is forwarded into the capture
    logic        w_rsp_fire, w_rsp_latch;
    logic [31:0] w_last_data;
    logic [1:0]  w_last_resp, w_capture_op;
    assign w_rsp_fire   = (r_dmi_state == DmiRsp) && dmi.dmi_rsp_valid_i;
    assign w_rsp_latch  = w_rsp_fire && !r_discard;
    assign w_last_data  = w_rsp_latch ? dmi.dmi_rsp_data_i : r_last_rsp.data;
    assign w_last_resp  = w_rsp_latch ? dmi.dmi_rsp_resp_i : r_last_rsp.resp;
    assign w_capture_op = (r_dmistat == DmiStatBusy) ? DmiStatBusy : w_last_resp;
    assign w_dr_sel     = decode_ir(r_ir);

    logic [31:0]         w_dtmcs_capture;
    logic [DmiWidth-1:0] w_dmi_capture;
    assign w_dtmcs_capture = {14'b0, 3'b0, DtmcsIdle, r_dmistat, 6'(AbitsWidth), DtmcsVersion};
    assign w_dmi_capture   = {r_last_addr, w_last_data, w_capture_op};

    always_comb begin
        w_dr_msb     = '0;
        w_dr_capture = '0;
        case (w_dr_sel)
            DrIdcode: begin w_dr_msb = DrIdxW'(31);         w_dr_capture = DrWidth'(IdcodeValue);     end
            DrDtmcs:  begin w_dr_msb = DrIdxW'(31);         w_dr_capture = DrWidth'(w_dtmcs_capture); end
            DrDmi:    begin w_dr_msb = DrIdxW'(DmiWidth-1); w_dr_capture = DrWidth'(w_dmi_capture);   end
            default:  begin w_dr_msb = '0;                  w_dr_capture = '0;                        end
        endcase
        w_dr_shifted           = r_dr >> 1;
        w_dr_shifted[w_dr_msb] = w_tdi;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)           r_dr <= '0;
        else if (w_capture_dr) r_dr <= w_dr_capture;
        else if (w_shift_dr)   r_dr <= w_dr_shifted;
    end

    logic r_tdo, r_tdo_oe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo_oe <= (r_tap_state == TapShiftDr) || (r_tap_state == TapShiftIr);
            if (w_tck_fall) r_tdo <= is_ir_state(r_tap_state) ? r_ir_shift[0] : r_dr[0];
        end
    end

    logic w_dmi_update, w_dtmcs_update, w_dmi_issue, w_dmi_collide;
    assign w_dmi_update   = w_update_dr && (w_dr_sel == DrDmi);
    assign w_dtmcs_update = w_update_dr && (w_dr_sel == DrDtmcs);
    assign w_dmi_issue    = w_dmi_update && (r_dmi_state == DmiIdle) &&
                            ((r_dr[1:0] == DmiOpRead) || (r_dr[1:0] == DmiOpWrite));
    assign w_dmi_collide  = w_dmi_update && (r_dmi_state != DmiIdle);

    always_comb begin
        w_dmi_next = r_dmi_state;
        case (r_dmi_state)
            DmiIdle: if (w_dmi_issue)          w_dmi_next = DmiReq;
            DmiReq:  if (dmi.dmi_req_ready_i)  w_dmi_next = DmiRsp;
            DmiRsp:  if (dmi.dmi_rsp_valid_i)  w_dmi_next = DmiIdle;
            default:                           w_dmi_next = DmiIdle;
        endcase
    end

    // Later assignments take priority: DTMCS resets override busy/failed set in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dmi_state <= DmiIdle;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_req       <= '0;
            r_last_addr <= '0;
            r_last_rsp  <= '0;
            r_dmistat   <= DmiStatOk;
            r_discard   <= 1'b0;
        end else begin
            r_dmi_state <= w_dmi_next;
            r_req_valid <= (w_dmi_next == DmiReq);
            r_rsp_ready <= (w_dmi_next == DmiRsp);
            if (w_dmi_issue) begin
                r_req       <= r_dr[DmiWidth-1:0];
                r_last_addr <= r_dr[DmiWidth-1 -: AbitsWidth];
            end
            if (w_rsp_fire) r_discard <= 1'b0;
            if (w_rsp_latch) begin
                r_last_rsp.data <= dmi.dmi_rsp_data_i;
                r_last_rsp.resp <= dmi.dmi_rsp_resp_i;
                if (dmi.dmi_rsp_resp_i == DmiStatFailed && r_dmistat == DmiStatOk)
                    r_dmistat <= DmiStatFailed;
            end
            if (w_dmi_collide) r_dmistat <= DmiStatBusy;
            if (w_dtmcs_update && (r_dr[DtmcsDmiresetBit] || r_dr[DtmcsHardresetBit]))
                r_dmistat <= DmiStatOk;
            if (w_dtmcs_update && r_dr[DtmcsHardresetBit] && (w_dmi_next != DmiIdle))
                r_discard <= 1'b1;
        end
    end

    assign jtag_tdo_o          = r_tdo;
    assign jtag_tdo_oe_o       = r_tdo_oe;
    assign dmi.dmi_req_valid_o = r_req_valid;
    assign dmi.dmi_req_o       = r_req;
    assign dmi.dmi_rsp_ready_o = r_rsp_ready;
endmodule

// File: tb/tb_rvlab_jtag_dtm.sv
// Directed bench for rvlab_jtag_dtm acting as a JTAG master and a simple debug module.
module tb_rvlab_jtag_dtm;
    import rvlab_jtag_pkg::*;

    localparam int unsigned Abits = 7;
    localparam int unsigned DmiW  = Abits + 34;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic tck    = 1'b0;
    logic tms    = 1'b1;
    logic tdi    = 1'b0;
    logic trst_n = 1'b1;
    logic tdo, tdo_oe;

    int checks = 0;
    int errors = 0;

    rvlab_jtag_dtm_if #(.AbitsWidth(Abits)) dmi_bus ();

    rvlab_jtag_dtm #(.IdcodeValue(32'h0000_0001), .AbitsWidth(Abits)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .jtag_tck_i    (tck),
        .jtag_tms_i    (tms),
        .jtag_tdi_i    (tdi),
        .jtag_trst_ni  (trst_n),
        .jtag_tdo_o    (tdo),
        .jtag_tdo_oe_o (tdo_oe),
        .dmi           (dmi_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dmi_vec(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dmi_req_t r;
        r = '{addr: a, data: d, op: op};
        return 64'(r);
    endfunction

    // One TCK period: TDO is sampled just before the rising edge
    task automatic tick(input logic t_ms, input logic t_di, output logic t_do, output logic t_oe);
        tms = t_ms;
        tdi = t_di;
        repeat (8) @(negedge clk);
        t_do = tdo;
        t_oe = tdo_oe;
        tck  = 1'b1;
        repeat (8) @(negedge clk);
        tck  = 1'b0;
    endtask

    task automatic ir_scan(input logic [4:0] ir, output logic [4:0] ir_out);
        logic d, o;
        tick(1'b1, 1'b0, d, o);
        tick(1'b1, 1'b0, d, o);
        tick(1'b0, 1'b0, d, o);
        tick(1'b0, 1'b0, d, o);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, ir[i], d, o);
            ir_out[i] = d;
        end
        tick(1'b1, 1'b0, d, o);
        tick(1'b0, 1'b0, d, o);
    endtask

    task automatic dr_scan(input logic [63:0] din, input int len, output logic [63:0] dout, output logic oe_ok);
        logic d, o;
        dout  = '0;
        oe_ok = 1'b1;
        tick(1'b1, 1'b0, d, o); oe_ok &= ~o;
        tick(1'b0, 1'b0, d, o); oe_ok &= ~o;
        tick(1'b0, 1'b0, d, o); oe_ok &= ~o;
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, din[i], d, o);
            dout[i] = d;
            oe_ok &= o;
        end
        tick(1'b1, 1'b0, d, o); oe_ok &= ~o;
        tick(1'b0, 1'b0, d, o); oe_ok &= ~o;
    endtask

    task automatic dm_serve(input logic [31:0] data, input logic [1:0] resp);
        check("serve_valid", 64'(dmi_bus.dmi_req_valid_o), 64'd1);
        dmi_bus.dmi_req_ready_i = 1'b1;
        @(negedge clk);
        dmi_bus.dmi_req_ready_i = 1'b0;
        check("serve_accept", 64'({dmi_bus.dmi_req_valid_o, dmi_bus.dmi_rsp_ready_o}), 64'b01);
        dmi_bus.dmi_rsp_valid_i = 1'b1;
        dmi_bus.dmi_rsp_data_i  = data;
        dmi_bus.dmi_rsp_resp_i  = resp;
        @(negedge clk);
        dmi_bus.dmi_rsp_valid_i = 1'b0;
        check("serve_done", 64'(dmi_bus.dmi_rsp_ready_o), 64'd0);
    endtask

    initial begin
        logic [63:0] dout;
        logic [4:0]  irq;
        logic        ok, d, o;
        dmi_bus.dmi_req_ready_i = 1'b0;
        dmi_bus.dmi_rsp_valid_i = 1'b0;
        dmi_bus.dmi_rsp_data_i  = '0;
        dmi_bus.dmi_rsp_resp_i  = '0;

        repeat (3) @(negedge clk);
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        check("rst_req_valid", 64'(dmi_bus.dmi_req_valid_o), 64'd0);
        check("rst_rsp_ready", 64'(dmi_bus.dmi_rsp_ready_o), 64'd0);
        check("rst_req", 64'(dmi_bus.dmi_req_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // IDCODE after TAP reset via TMS
        repeat (5) tick(1'b1, 1'b0, d, o);
        tick(1'b0, 1'b0, d, o);
        dr_scan(64'd0, 32, dout, ok);
        check("idcode", dout, 64'h0000_0001);
        check("idcode_oe", 64'(ok), 64'd1);

        // DTMCS read
        ir_scan(IrDtmcs, irq);
        check("ir_capture", 64'(irq), 64'b00001);
        dr_scan(64'd0, 32, dout, ok);
        check("dtmcs", dout, 64'h0000_1071);
        check("dtmcs_oe", 64'(ok), 64'd1);

        // DMI write with ready held off for 5 cycles
        ir_scan(IrDmi, irq);
        dr_scan(dmi_vec(7'h10, 32'h1, 2'd2), DmiW, dout, ok);
        check("dmi_cap0", dout, dmi_vec(7'h0, 32'h0, 2'd0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wr_valid_hold", 64'(dmi_bus.dmi_req_valid_o), 64'd1);
            check("wr_payload", 64'(dmi_bus.dmi_req_o), dmi_vec(7'h10, 32'h1, 2'd2));
        end
        dm_serve(32'h0, 2'd0);

        // DMI read; capture reflects the write response
        dr_scan(dmi_vec(7'h11, 32'h0, 2'd1), DmiW, dout, ok);
        check("dmi_cap_wr", dout, dmi_vec(7'h10, 32'h0, 2'd0));
        check("rd_payload", 64'(dmi_bus.dmi_req_o), dmi_vec(7'h11, 32'h0, 2'd1));
        dm_serve(32'hDEAD_BEEF, 2'd0);
        dr_scan(dmi_vec(7'h0, 32'h0, 2'd0), DmiW, dout, ok);
        check("dmi_cap_rd", dout, dmi_vec(7'h11, 32'hDEAD_BEEF, 2'd0));

        // Second update while a read is outstanding -> dropped, sticky busy
        dr_scan(dmi_vec(7'h12, 32'h0, 2'd1), DmiW, dout, ok);
        dr_scan(dmi_vec(7'h13, 32'h0, 2'd1), DmiW, dout, ok);
        check("dmi_cap_pending", dout, dmi_vec(7'h12, 32'hDEAD_BEEF, 2'd0));
        check("busy_payload", 64'(dmi_bus.dmi_req_o), dmi_vec(7'h12, 32'h0, 2'd1));
        dm_serve(32'hCAFE_F00D, 2'd0);
        repeat (20) @(negedge clk);
        check("no_second_req", 64'(dmi_bus.dmi_req_valid_o), 64'd0);
        dr_scan(dmi_vec(7'h0, 32'h0, 2'd0), DmiW, dout, ok);
        check("dmi_cap_busy", dout, dmi_vec(7'h12, 32'hCAFE_F00D, 2'd3));

        // dmireset clears sticky busy
        ir_scan(IrDtmcs, irq);
        dr_scan(64'd0, 32, dout, ok);
        check("dtmcs_busy", dout, 64'h0000_1C71);
        dr_scan(64'h0001_0000, 32, dout, ok);
        dr_scan(64'd0, 32, dout, ok);
        check("dtmcs_dmireset", dout, 64'h0000_1071);

        // Failed response sets dmistat=2; dmihardreset clears it
        ir_scan(IrDmi, irq);
        dr_scan(dmi_vec(7'h20, 32'h55, 2'd2), DmiW, dout, ok);
        check("dmi_cap_cleared", dout, dmi_vec(7'h12, 32'hCAFE_F00D, 2'd0));
        dm_serve(32'h0, 2'd2);
        dr_scan(dmi_vec(7'h0, 32'h0, 2'd0), DmiW, dout, ok);
        check("dmi_cap_failed", dout, dmi_vec(7'h20, 32'h0, 2'd2));
        ir_scan(IrDtmcs, irq);
        dr_scan(64'd0, 32, dout, ok);
        check("dtmcs_failed", dout, 64'h0000_1871);
        dr_scan(64'h0002_0000, 32, dout, ok);
        dr_scan(64'd0, 32, dout, ok);
        check("dtmcs_hardreset", dout, 64'h0000_1071);

        // BYPASS, both explicit and via an unknown code
        ir_scan(IrBypass, irq);
        dr_scan(64'hB2, 8, dout, ok);
        check("bypass_1f", dout, 64'h64);
        ir_scan(5'h05, irq);
        dr_scan(64'h4D, 8, dout, ok);
        check("bypass_05", dout, 64'h9A);

        // rst_ni during an outstanding request
        ir_scan(IrDmi, irq);
        dr_scan(dmi_vec(7'h30, 32'hA5, 2'd2), DmiW, dout, ok);
        check("pre_rst_valid", 64'(dmi_bus.dmi_req_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_valid", 64'(dmi_bus.dmi_req_valid_o), 64'd0);
        check("rst_drop_req", 64'(dmi_bus.dmi_req_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick(1'b0, 1'b0, d, o);
        dr_scan(64'd0, 32, dout, ok);
        check("rst_ir_idcode", dout, 64'h0000_0001);

`ifdef RVLAB_JTAG_TRST_EN
        // TRST in the middle of a DTMCS Shift-DR
        ir_scan(IrDtmcs, irq);
        tick(1'b1, 1'b0, d, o);
        tick(1'b0, 1'b0, d, o);
        repeat (3) tick(1'b0, 1'b1, d, o);
        trst_n = 1'b0;
        repeat (4) @(negedge clk);
        trst_n = 1'b1;
        repeat (4) @(negedge clk);
        tick(1'b0, 1'b0, d, o);
        dr_scan(64'd0, 32, dout, ok);
        check("trst_ir_idcode", dout, 64'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
